uart_tx_fifo: RTL

//   Parametrised UART transmitter with an internal baud divider and a small write FIFO.

---
 rtl/uart_tx_fifo.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal baud divider and a small write FIFO.
// Frames are sent LSB-first with optional parity and 1 or 2 stop bits.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          din,
    input  logic                          wr_en,
    output logic                          full,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          tx,
    output logic                          tx_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [CW-1:0]        r_cnt;
    logic                 r_ovf;

    state_t               r_state;
    logic [BW-1:0]        r_baud;
    logic [IW-1:0]        r_idx;
    logic                 r_stop_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_tx;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_wr;
    logic                 w_pop;
    logic                 w_bit_end;
    logic                 w_stop_end;
    logic [DATA_BITS-1:0] w_head;

    always_comb begin
        w_full     = (r_cnt == CW'(FIFO_DEPTH));
        w_empty    = (r_cnt == '0);
        w_wr       = wr_en & ~w_full;
        w_bit_end  = (r_baud == BW'(CLKS_PER_BIT - 1));
        w_stop_end = (r_state == S_STOP) & w_bit_end & (r_stop_idx == 1'(STOP_BITS - 1));
        w_pop      = ~w_empty & ((r_state == S_IDLE) | w_stop_end);
        w_head     = r_mem[r_rptr];
    end

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_ovf <= wr_en & w_full;
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // tx is registered from the current state, so the line trails the state by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_baud     <= '0;
            r_idx      <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_baud <= '0;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_par   <= (^w_head) ^ 1'(PARITY_ODD);
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_tx <= 1'b0;
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_idx   <= '0;
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                S_DATA: begin
                    r_tx <= r_shift[0];
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_shift <= r_shift >> 1;
                        if (r_idx == IW'(DATA_BITS - 1)) begin
                            r_stop_idx <= 1'b0;
                            r_state    <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                S_PARITY: begin
                    r_tx <= r_par;
                    if (w_bit_end) begin
                        r_baud     <= '0;
                        r_stop_idx <= 1'b0;
                        r_state    <= S_STOP;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (w_stop_end) begin
                            if (w_pop) begin
                                r_shift <= w_head;
                                r_par   <= (^w_head) ^ 1'(PARITY_ODD);
                                r_state <= S_START;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_stop_idx <= ~r_stop_idx;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_baud  <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign full     = w_full;
    assign overflow = r_ovf;
    assign fifo_cnt = r_cnt;
    assign tx       = r_tx;
    assign tx_busy  = (r_state != S_IDLE) | ~w_empty;

endmodule
